uart_tx_scheduler: RTL and testbench

- Shares one 8N1 UART transmit line between NUM_REQ byte-stream requesters, with round-robin arbitration.
- Sequences the external baud tick generator: drives its enable and consumes its tick (Oversampling = 1).
- Sits between the game-logic producers (move reporter, status/debug channel) and the TX pin.

---
 rtl/uart_tx_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one 8N1 UART transmit line between NUM_REQ
// byte requesters, gating an external baud tick generator for each frame.
module uart_tx_scheduler #(
   parameter int NUM_REQ   = 2,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 baud_tick,
   output logic                 baud_en,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   ack,
   output logic [2:0]           grant_id,
   output logic                 busy,
   output logic                 txd,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   localparam logic [1:0]         STOP_LAST = 2'(STOP_BITS - 1);
   localparam logic [2:0]         PTR_INIT  = 3'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ACK_ONE   = {{(NUM_REQ-1){1'b0}}, 1'b1};

   state_t             r_state;
   state_t             w_state_nxt;
   logic [7:0]         r_shift;
   logic [7:0]         w_shift_nxt;
   logic [2:0]         r_bit_cnt;
   logic [2:0]         w_bit_cnt_nxt;
   logic [1:0]         r_stop_cnt;
   logic [1:0]         w_stop_cnt_nxt;
   logic               r_txd;
   logic               w_txd_nxt;
   logic               r_baud_en;
   logic               w_baud_en_nxt;
   logic               r_busy;
   logic               w_busy_nxt;
   logic [NUM_REQ-1:0] r_ack;
   logic [NUM_REQ-1:0] w_ack_nxt;
   logic [2:0]         r_grant_id;
   logic [2:0]         w_grant_id_nxt;
   logic [2:0]         r_last_grant;
   logic [2:0]         w_last_grant_nxt;

   logic               w_any_req;
   logic [2:0]         w_winner;
   logic [7:0]         w_win_data;
   int                 w_dist;
   int                 w_best_dist;

   // Handshake: a requester holds req[i] and its byte stable until it sees the
   // one-cycle ack[i]; dropping req[i] earlier withdraws it. req/req_data are
   // only looked at in IDLE, so nothing a requester does mid-frame has effect.
   assign w_any_req = |req;

   // Rotating priority: the requester just after the last grant is closest.
   always_comb begin
      w_winner    = 3'd0;
      w_dist      = 0;
      w_best_dist = NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_dist = (i + 2 * NUM_REQ - int'(r_last_grant) - 1) % NUM_REQ;
         if (req[i] && (w_dist < w_best_dist)) begin
            w_best_dist = w_dist;
            w_winner    = 3'(i);
         end
      end
   end

   always_comb begin
      w_win_data = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_winner == 3'(i)) begin
            w_win_data = req_data[8*i +: 8];
         end
      end
   end

   // State register plus the registered outputs and datapath.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_shift      <= 8'h00;
         r_bit_cnt    <= 3'd0;
         r_stop_cnt   <= 2'd0;
         r_txd        <= 1'b1;
         r_baud_en    <= 1'b0;
         r_busy       <= 1'b0;
         r_ack        <= '0;
         r_grant_id   <= 3'd0;
         r_last_grant <= PTR_INIT;
      end else begin
         r_state      <= w_state_nxt;
         r_shift      <= w_shift_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_stop_cnt   <= w_stop_cnt_nxt;
         r_txd        <= w_txd_nxt;
         r_baud_en    <= w_baud_en_nxt;
         r_busy       <= w_busy_nxt;
         r_ack        <= w_ack_nxt;
         r_grant_id   <= w_grant_id_nxt;
         r_last_grant <= w_last_grant_nxt;
      end
   end

   // Next-state logic. IDLE ignores baud_tick, so a tick on the acceptance edge
   // cannot shorten START.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) w_state_nxt = S_START;
         end
         S_START: begin
            if (baud_tick) w_state_nxt = S_DATA;
         end
         S_DATA: begin
            if (baud_tick && (r_bit_cnt == 3'd7)) w_state_nxt = S_STOP;
         end
         S_STOP: begin
            if (baud_tick && (r_stop_cnt == STOP_LAST)) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output and datapath next values; everything here lands in a register.
   always_comb begin
      w_shift_nxt      = r_shift;
      w_bit_cnt_nxt    = r_bit_cnt;
      w_stop_cnt_nxt   = r_stop_cnt;
      w_txd_nxt        = r_txd;
      w_baud_en_nxt    = r_baud_en;
      w_busy_nxt       = r_busy;
      w_ack_nxt        = '0;
      w_grant_id_nxt   = r_grant_id;
      w_last_grant_nxt = r_last_grant;
      case (r_state)
         S_IDLE: begin
            w_txd_nxt     = 1'b1;
            w_baud_en_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
            if (w_any_req) begin
               w_shift_nxt      = w_win_data;
               w_txd_nxt        = 1'b0;
               w_baud_en_nxt    = 1'b1;
               w_busy_nxt       = 1'b1;
               w_ack_nxt        = ACK_ONE << w_winner;
               w_grant_id_nxt   = w_winner;
               w_last_grant_nxt = w_winner;
            end
         end
         S_START: begin
            if (baud_tick) begin
               w_txd_nxt     = r_shift[0];
               w_shift_nxt   = {1'b0, r_shift[7:1]};
               w_bit_cnt_nxt = 3'd0;
            end
         end
         S_DATA: begin
            if (baud_tick) begin
               if (r_bit_cnt == 3'd7) begin
                  w_txd_nxt      = 1'b1;
                  w_stop_cnt_nxt = 2'd0;
               end else begin
                  w_txd_nxt     = r_shift[0];
                  w_shift_nxt   = {1'b0, r_shift[7:1]};
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               end
            end
         end
         S_STOP: begin
            w_txd_nxt = 1'b1;
            if (baud_tick) begin
               if (r_stop_cnt == STOP_LAST) begin
                  w_baud_en_nxt = 1'b0;
                  w_busy_nxt    = 1'b0;
               end else begin
                  w_stop_cnt_nxt = r_stop_cnt + 2'd1;
               end
            end
         end
         default: begin
            w_txd_nxt = 1'b1;
         end
      endcase
   end

   assign txd       = r_txd;
   assign baud_en   = r_baud_en;
   assign busy      = r_busy;
   assign ack       = r_ack;
   assign grant_id  = r_grant_id;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a baud generator model, an 8N1 receiver model
// and a scoreboard of {grant_id, byte} frames expected on the line.
module tb_uart_tx_scheduler;

   localparam int NREQ        = 3;
   localparam int SB          = 2;
   localparam int TICK_DIV    = 16;
   localparam int FRAME_TICKS = 9 + SB;

   logic              clk = 1'b0;
   logic              reset;
   logic              baud_tick;
   logic              baud_en;
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   ack;
   logic [2:0]        grant_id;
   logic              busy;
   logic              txd;
   logic [1:0]        dbg_state;

   uart_tx_scheduler #(.NUM_REQ(NREQ), .STOP_BITS(SB)) dut (
      .clk       (clk),
      .reset     (reset),
      .baud_tick (baud_tick),
      .baud_en   (baud_en),
      .req       (req),
      .req_data  (req_data),
      .ack       (ack),
      .grant_id  (grant_id),
      .busy      (busy),
      .txd       (txd),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int              n_vec = 0;
   int              n_err = 0;
   logic [10:0]     exp_q[$];
   logic [2:0]      grant_log[$];
   int              cyc = 0;
   int              gen_cnt = 0;
   int              frames_done = 0;
   int              last_done_cyc = 0;
   int              last_ack_gap = 0;
   int              rx_ticks = 0;
   logic            stray = 1'b0;
   logic            rx_active = 1'b0;
   logic [7:0]      rx_byte = 8'h00;
   logic [2:0]      rx_id = 3'd0;
   logic [NREQ-1:0] ack_prev = '0;

   // One clock: drive the tick for the coming edge, then sample and decode.
   task automatic step();
      logic [10:0] exp_item;
      logic [2:0]  oh;
      if (baud_en === 1'b1) begin
         gen_cnt++;
         baud_tick = (gen_cnt == TICK_DIV);
         if (gen_cnt == TICK_DIV) gen_cnt = 0;
      end else begin
         gen_cnt   = 0;
         baud_tick = 1'b0;
      end
      if (stray) begin
         baud_tick = 1'b1;
         stray     = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
         rx_active = 1'b0;
         ack_prev  = '0;
         gen_cnt   = 0;
      end else begin
         if (ack !== '0) begin
            oh = 3'b001 << grant_id;
            n_vec++;
            if ($countones(ack) != 1) begin n_err++; $display("FAIL ack_onehot: ack=%b expected one-hot", ack); end
            n_vec++;
            if (ack_prev !== '0) begin n_err++; $display("FAIL ack_width: previous ack=%b expected 000", ack_prev); end
            n_vec++;
            if (rx_active) begin n_err++; $display("FAIL preempt: ack=%b during frame, expected none", ack); end
            n_vec++;
            if (ack !== oh) begin n_err++; $display("FAIL ack_vs_grant: ack=%b expected %b", ack, oh); end
            n_vec++;
            if ({txd, busy, baud_en} !== 3'b011) begin
               n_err++; $display("FAIL accept_outputs: txd,busy,baud_en=%b expected 011", {txd, busy, baud_en});
            end
            rx_active    = 1'b1;
            rx_ticks     = 0;
            rx_byte      = 8'h00;
            rx_id        = grant_id;
            last_ack_gap = cyc - last_done_cyc;
            grant_log.push_back(grant_id);
         end else if (rx_active) begin
            if (baud_tick) begin
               rx_ticks++;
               if (rx_ticks <= 8) begin
                  rx_byte = {txd, rx_byte[7:1]};
               end else if (rx_ticks < FRAME_TICKS) begin
                  n_vec++;
                  if ({txd, busy, baud_en} !== 3'b111) begin
                     n_err++; $display("FAIL stop_phase: tick %0d txd,busy,baud_en=%b expected 111", rx_ticks, {txd, busy, baud_en});
                  end
               end else begin
                  n_vec++;
                  if ({txd, busy, baud_en} !== 3'b100) begin
                     n_err++; $display("FAIL frame_end: txd,busy,baud_en=%b expected 100", {txd, busy, baud_en});
                  end
                  n_vec++;
                  if (exp_q.size() == 0) begin
                     n_err++; $display("FAIL frame_unexpected: got id %0d byte %h, expected no frame", rx_id, rx_byte);
                  end else begin
                     exp_item = exp_q.pop_front();
                     if ({rx_id, rx_byte} !== exp_item) begin
                        n_err++; $display("FAIL frame_data: got id %0d byte %h expected id %0d byte %h", rx_id, rx_byte, exp_item[10:8], exp_item[7:0]);
                     end
                  end
                  rx_active     = 1'b0;
                  frames_done++;
                  last_done_cyc = cyc;
               end
            end else if (rx_ticks == 0) begin
               n_vec++;
               if ({txd, busy} !== 2'b01) begin n_err++; $display("FAIL start_bit: txd,busy=%b expected 01", {txd, busy}); end
            end
         end else begin
            n_vec++;
            if ({txd, busy, baud_en} !== 3'b100) begin
               n_err++; $display("FAIL idle_outputs: txd,busy,baud_en=%b expected 100", {txd, busy, baud_en});
            end
         end
         ack_prev = ack;
      end
   endtask

   task automatic run_frames(input int nf, input logic [NREQ-1:0] drop_mask);
      int target;
      int budget;
      target = frames_done + nf;
      budget = nf * (FRAME_TICKS * TICK_DIV + 40) + 20;
      while ((frames_done < target) && (budget > 0)) begin
         step();
         req = req & ~(ack & drop_mask);
         budget--;
      end
      n_vec++;
      if (frames_done < target) begin n_err++; $display("FAIL run_frames_timeout: frames %0d expected %0d", frames_done, target); end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      step();
      reset = 1'b0;
      exp_q.delete();
      grant_log.delete();
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      req      = '0;
      req_data = '0;
      step();
      step();
      n_vec++; if (txd !== 1'b1)       begin n_err++; $display("FAIL reset_txd: got %b expected 1", txd); end
      n_vec++; if (baud_en !== 1'b0)   begin n_err++; $display("FAIL reset_baud_en: got %b expected 0", baud_en); end
      n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_vec++; if (ack !== '0)         begin n_err++; $display("FAIL reset_ack: got %b expected 000", ack); end
      n_vec++; if (grant_id !== 3'd0)  begin n_err++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
      n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
      reset = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      req      = 3'b001;
      req_data = {8'h00, 8'h00, 8'hA5};
      exp_q.push_back({3'd0, 8'hA5});
      step();
      n_vec++; if (ack !== 3'b001) begin n_err++; $display("FAIL single_ack_latency: ack=%b expected 001", ack); end
      req = '0;
      run_frames(1, '0);
   endtask

   task automatic test_simultaneous();
      do_reset();
      req      = 3'b011;
      req_data = {8'h00, 8'hC3, 8'h3C};
      exp_q.push_back({3'd0, 8'h3C});
      exp_q.push_back({3'd1, 8'hC3});
      run_frames(2, 3'b011);
      n_vec++;
      if (last_ack_gap != 1) begin n_err++; $display("FAIL b2b_gap: idle clks %0d expected 1", last_ack_gap); end
      req = '0;
   endtask

   task automatic test_fairness();
      logic [7:0] bytes [NREQ];
      bytes[0] = 8'h5B;
      bytes[1] = 8'hE4;
      bytes[2] = 8'h19;
      do_reset();
      req      = 3'b111;
      req_data = {bytes[2], bytes[1], bytes[0]};
      for (int i = 0; i < 6; i++) exp_q.push_back({3'(i % NREQ), bytes[i % NREQ]});
      run_frames(6, '0);
      req = '0;
      n_vec++;
      if (grant_log.size() != 6) begin n_err++; $display("FAIL fair_count: grants %0d expected 6", grant_log.size()); end
      for (int i = 0; i < grant_log.size(); i++) begin
         n_vec++;
         if (grant_log[i] !== 3'(i % NREQ)) begin
            n_err++; $display("FAIL fair_order: grant %0d got %0d expected %0d", i, grant_log[i], i % NREQ);
         end
      end
   endtask

   task automatic test_stray_ticks();
      do_reset();
      stray = 1'b1;
      step();
      n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL idle_tick_state: got %0d expected 0", dbg_state); end
      stray = 1'b1;
      step();
      req      = 3'b001;
      req_data = {8'h00, 8'h00, 8'h5A};
      exp_q.push_back({3'd0, 8'h5A});
      stray = 1'b1;
      step();
      n_vec++; if (ack !== 3'b001) begin n_err++; $display("FAIL stray_accept: ack=%b expected 001", ack); end
      req = '0;
      run_frames(1, '0);
   endtask

   task automatic test_abort();
      int budget;
      do_reset();
      req      = 3'b001;
      req_data = {8'h00, 8'h00, 8'h96};
      exp_q.push_back({3'd0, 8'h96});
      step();
      req = '0;
      budget = 200;
      while ((rx_ticks < 5) && rx_active && (budget > 0)) begin
         step();
         budget--;
      end
      n_vec++; if (rx_ticks != 5) begin n_err++; $display("FAIL abort_reach_bit4: ticks %0d expected 5", rx_ticks); end
      n_vec++; if (dbg_state !== 2'd2) begin n_err++; $display("FAIL abort_in_data: state %0d expected 2", dbg_state); end
      reset    = 1'b1;
      req      = 3'b011;
      req_data = {8'h00, 8'h4D, 8'hB2};
      step();
      n_vec++;
      if ({txd, baud_en, busy} !== 3'b100) begin
         n_err++; $display("FAIL abort_outputs: txd,baud_en,busy=%b expected 100", {txd, baud_en, busy});
      end
      n_vec++; if (ack !== '0) begin n_err++; $display("FAIL abort_ack: got %b expected 000", ack); end
      n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL abort_state: got %0d expected 0", dbg_state); end
      reset = 1'b0;
      exp_q.delete();
      grant_log.delete();
      exp_q.push_back({3'd0, 8'hB2});
      exp_q.push_back({3'd1, 8'h4D});
      run_frames(2, 3'b011);
      req = '0;
   endtask

   task automatic test_withdraw();
      logic saw;
      do_reset();
      req      = 3'b001;
      req_data = {8'h00, 8'h77, 8'h81};
      exp_q.push_back({3'd0, 8'h81});
      step();
      req = '0;
      repeat (20) step();
      req[1] = 1'b1;
      step();
      req[1]        = 1'b0;
      req_data[7:0] = 8'hFF;
      run_frames(1, '0);
      saw = 1'b0;
      repeat (40) begin
         step();
         if (ack !== '0) saw = 1'b1;
      end
      n_vec++; if (saw) begin n_err++; $display("FAIL withdraw_grant: ack seen after withdrawn request, expected none"); end
   endtask

   initial begin
      reset     = 1'b1;
      baud_tick = 1'b0;
      req       = '0;
      req_data  = '0;
      test_reset();
      test_single();
      test_simultaneous();
      test_fairness();
      test_stray_ticks();
      test_abort();
      test_withdraw();
      n_vec++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL leftover_frames: %0d pending expected 0", exp_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
